aes_dec_key_scheduler: RTL and testbench
========================================

// Module: aes_dec_key_scheduler
// PURPOSE
//  AES-128 decryption round-key sequencer; feeds the inverse cipher datapath, which consumes keys last-to-first.
//  - Accepts the cipher key.
//  - Expands forward to round key 10, one round per cycle.
//  - Issues round keys 10,9,...,0 over a valid/ready stream, deriving each earlier key by one inverse
//    key-schedule step per handshake.
//  - Caches round key 10, so the same key can be replayed without re-expansion.
// PARAMETERS
//  ROUNDS  10  number of cipher rounds; only 10 (AES-128) is legal; other values are an elaboration error
// PORTS
//  Clk         in   1    single clock, rising edge
//  Rst_n       in   1    asynchronous reset, active low
//  Key_valid   in   1    cipher key offered
//  Key_ready   out  1    block idle and able to accept a key
//  Key         in   128  cipher key; w0 = [127:96] ... w3 = [31:0]; byte 0 = [127:120] (FIPS-197 order)
//  Restart     in   1    one-cycle request to reissue the cached key sequence from round 10
//  Rkey_valid  out  1    round key presented
//  Rkey_ready  in   1    consumer accepts round key
//  Rkey        out  128  round key, same word/byte order as Key
//  Rkey_round  out  4    round index of Rkey (10..0)
//  Rkey_last   out  1    high when Rkey_round == 0
// BEHAVIOUR
//  Reset values: Key_ready=1, Rkey_valid=0, Rkey=0, Rkey_round=0, Rkey_last=0, cache invalid, state IDLE.
//  Reset asserted mid-operation aborts immediately to these values; no partial output survives.
//  Forward step from round key r-1 to r (r = 1..10):
//   - t = SubWord(RotWord(k3)) ^ {Rcon[r],24'h0}
//   - n0 = k0^t, n1 = k1^n0, n2 = k2^n1, n3 = k3^n2
//  Inverse step from round key r to r-1:
//   - p3 = k3^k2, p2 = k2^k1, p1 = k1^k0
//   - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
//  Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
//  One 4-byte forward S-box lookup serves both steps; its input is muxed by state.
//  FSM states:
//   IDLE:
//    - Key_ready=1.
//    - Key_valid&Key_ready: load Key into the work register, cnt=1, go to EXPAND.
//    - Restart with cache valid and no Key_valid: load the cache, Rkey_round=10, go to ISSUE.
//    - Key_valid and Restart together: Key wins.
//    - Restart with no cached key: ignored.
//   EXPAND:
//    - Key_ready=0.
//    - Each cycle applies one forward step with Rcon[cnt] and increments cnt.
//    - On the step with cnt==10: write the result to the work register and the cache, set cache valid,
//      go to ISSUE with Rkey_round=10.
//    - Key accepted on edge N gives Rkey_valid high after edge N+10.
//   ISSUE:
//    - Rkey_valid=1, Rkey = work register.
//    - While Rkey_ready=0, Rkey, Rkey_round and Rkey_last hold stable.
//    - Handshake with Rkey_round>0: apply one inverse step, Rkey_round-1; the next key is valid the
//      following cycle, so back-to-back handshakes give 1 key/cycle.
//    - Handshake with Rkey_round==0: Rkey_valid=0, return to IDLE.
//  Outside IDLE: Key_valid and Restart are ignored and no key is dropped silently (Key_ready=0).
//  The cache keeps its value until the next key load or reset.
//  Exactly 11 round keys are issued per sequence; Rkey_last is asserted only with round 0.
// TESTING
//  1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, Rkey_ready=1:
//     - Rkey_valid rises after edge N+10.
//     - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, round 9 = ac7766f319fadc2128d12941575c006e.
//     - Round 0 = the key, with Rkey_last=1; 11 beats on consecutive cycles.
//  2. Rkey_ready toggled randomly during the sequence in test 1 -> identical key sequence; Rkey stable
//     while stalled.
//  3. After test 1, pulse Restart in IDLE -> Rkey_valid rises the next cycle with round 10 key d014f9a8...;
//     no EXPAND cycles.
//  4. Restart after reset with no key loaded -> ignored; Key_valid+Restart together in IDLE -> key load
//     wins. Key_valid during EXPAND/ISSUE -> Key_ready=0, no effect.
//  5. Rst_n asserted during EXPAND and during ISSUE (round 5) -> all outputs return to reset values
//     asynchronously; a following Restart is ignored (cache invalid).
//  6. All-zero key -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; full reverse sequence matches a
//     reference model.

Source files
------------

// File: rtl/aes_dec_key_scheduler.sv
// AES-128 decryption round-key sequencer: expands the cipher key forward to round 10, then
// walks back to round 0 with one inverse key-schedule step per handshake. Round key 10 is cached for replay.
module aes_dec_key_scheduler #(
  parameter int ROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  input  logic         restart_i,
  output logic         rkey_valid_o,
  input  logic         rkey_ready_i,
  output logic [127:0] rkey_o,
  output logic [3:0]   rkey_round_o,
  output logic         rkey_last_o
);

  if (ROUNDS != 10) begin : g_bad_rounds
    $error("aes_dec_key_scheduler supports only ROUNDS = 10 (AES-128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, ISSUE} state_e;

  state_e       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [127:0] cache_q, cache_d;
  logic         cache_valid_q, cache_valid_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;

  // Shared S-box: forward step substitutes k3, inverse step substitutes the recovered p3 = k3^k2.
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sub_in, sub_out;
  logic [127:0] fwd_key, inv_key;

  assign {k0, k1, k2, k3} = work_q;
  assign sub_in  = (state_q == ISSUE) ? (k3 ^ k2) : k3;
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]});

  always_comb begin
    logic [31:0] t, n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    t  = sub_out ^ {rcon(cnt_q), 24'h0};
    n0 = k0 ^ t;
    n1 = k1 ^ n0;
    n2 = k2 ^ n1;
    n3 = k3 ^ n2;
    fwd_key = {n0, n1, n2, n3};
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    p0 = k0 ^ sub_out ^ {rcon(round_q), 24'h0};
    inv_key = {p0, p1, p2, p3};
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    cache_d       = cache_q;
    cache_valid_d = cache_valid_q;
    cnt_d         = cnt_q;
    round_d       = round_q;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          work_d  = key_i;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end else if (restart_i && cache_valid_q) begin
          work_d  = cache_q;
          round_d = LAST_ROUND;
          state_d = ISSUE;
        end
      end
      EXPAND: begin
        work_d = fwd_key;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND) begin
          cache_d       = fwd_key;
          cache_valid_d = 1'b1;
          round_d       = LAST_ROUND;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (rkey_ready_i) begin
          if (round_q != 4'd0) begin
            work_d  = inv_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      work_q        <= '0;
      cache_valid_q <= 1'b0;
      cnt_q         <= '0;
      round_q       <= '0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cache_valid_q <= cache_valid_d;
      cnt_q         <= cnt_d;
      round_q       <= round_d;
    end
  end

  // NOTE: cache data is left unreset; cache_valid_q gates every use of it.
  always_ff @(posedge clk_i) begin
    cache_q <= cache_d;
  end

  assign key_ready_o  = (state_q == IDLE);
  assign rkey_valid_o = (state_q == ISSUE);
  assign rkey_o       = (state_q == ISSUE) ? work_q : '0;
  assign rkey_round_o = (state_q == ISSUE) ? round_q : '0;
  assign rkey_last_o  = (state_q == ISSUE) && (round_q == 4'd0);

endmodule

// File: tb/tb_aes_dec_key_scheduler.sv
// Self-checking bench for aes_dec_key_scheduler: directed scenarios with random keys and
// random consumer back-pressure, checked against a FIPS-197 key-expansion model.
module tb_aes_dec_key_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         key_valid_i = 1'b0;
  logic         key_ready_o;
  logic [127:0] key_i = '0;
  logic         restart_i = 1'b0;
  logic         rkey_valid_o;
  logic         rkey_ready_i = 1'b0;
  logic [127:0] rkey_o;
  logic [3:0]   rkey_round_o;
  logic         rkey_last_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] seen_rk  [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_dec_key_scheduler #(.ROUNDS(10)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .restart_i    (restart_i),
    .rkey_valid_o (rkey_valid_o),
    .rkey_ready_i (rkey_ready_i),
    .rkey_o       (rkey_o),
    .rkey_round_o (rkey_round_o),
    .rkey_last_o  (rkey_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // GF(2^8) arithmetic for building the S-box from its algebraic definition.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sbox_tab[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  // Textbook 44-word key expansion; round key r is words 4r..4r+3.
  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]], sbox_tab[temp[15:8]], sbox_tab[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 128'(key_ready_o), 128'(1'b1));
    check({tag, "_rkey_valid"}, 128'(rkey_valid_o), 128'(1'b0));
    check({tag, "_rkey"}, rkey_o, 128'h0);
    check({tag, "_rkey_round"}, 128'(rkey_round_o), 128'(4'd0));
    check({tag, "_rkey_last"}, 128'(rkey_last_o), 128'(1'b0));
  endtask

  // Asserts reset mid-cycle, away from any clock edge, and checks outputs before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst_ni = 1'b0;
    key_valid_i = 1'b0;
    restart_i = 1'b0;
    rkey_ready_i = 1'b0;
    #1;
    check_reset_outputs(tag);
    step();
    rst_ni = 1'b1;
  endtask

  // Offers a key for one edge, then checks Rkey_valid rises exactly 10 edges later.
  // With noise set, Key_valid/Restart stay high during EXPAND with a different key.
  task automatic load_and_wait(input string tag, input logic [127:0] key, input bit noise);
    bit early = 1'b0;
    bit busy_ok = 1'b1;
    key_valid_i = 1'b1;
    key_i = key;
    step();
    key_valid_i = noise;
    restart_i = noise;
    key_i = ~key;
    for (int i = 1; i < 10; i++) begin
      if (rkey_valid_o) early = 1'b1;
      if (key_ready_o) busy_ok = 1'b0;
      step();
    end
    check({tag, "_not_early"}, 128'(early), 128'(1'b0));
    check({tag, "_busy_during_expand"}, 128'(busy_ok), 128'(1'b1));
    step();
    check({tag, "_latency"}, 128'(rkey_valid_o), 128'(1'b1));
  endtask

  // Consumes one full sequence and compares every beat with model_rk, 10 down to 0.
  task automatic run_seq(input string tag, input bit rand_ready, output int cycles);
    int beats = 0;
    bit prev_stall = 1'b0;
    logic [127:0] prev_rkey = '0;
    logic [3:0]   prev_round = '0;
    logic         ready;
    cycles = 0;
    while (beats < 11 && cycles < 300) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        check({tag, "_stall_rkey"}, rkey_o, prev_rkey);
        check({tag, "_stall_round"}, 128'(rkey_round_o), 128'(prev_round));
      end
      if (rkey_valid_o && ready) begin
        check({tag, "_rkey"}, rkey_o, model_rk[10-beats]);
        check({tag, "_round"}, 128'(rkey_round_o), 128'(10 - beats));
        check({tag, "_last"}, 128'(rkey_last_o), 128'(beats == 10));
        seen_rk[10-beats] = rkey_o;
        beats++;
      end
      prev_stall = rkey_valid_o && !ready;
      prev_rkey  = rkey_o;
      prev_round = rkey_round_o;
      rkey_ready_i = ready;
      step();
      cycles++;
    end
    rkey_ready_i = 1'b0;
    check({tag, "_beat_count"}, 128'(beats), 128'(11));
    check({tag, "_valid_after_last"}, 128'(rkey_valid_o), 128'(1'b0));
  endtask

  initial begin
    int cycles;
    logic [127:0] rkey;
    build_sbox();

    // Reset state.
    #3;
    check_reset_outputs("reset");
    step();
    rst_ni = 1'b1;
    step();

    // Restart with nothing cached is ignored.
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    step();
    check("restart_no_cache_valid", 128'(rkey_valid_o), 128'(1'b0));
    check("restart_no_cache_ready", 128'(key_ready_o), 128'(1'b1));

    // FIPS-197 A.1 with the consumer always ready: 11 beats on consecutive cycles.
    expand_model(FIPS_KEY);
    load_and_wait("fips", FIPS_KEY, 1'b0);
    check("fips_round10", rkey_o, FIPS_R10);
    run_seq("fips", 1'b0, cycles);
    check("fips_consecutive", 128'(cycles), 128'(11));
    check("fips_round9", seen_rk[9], FIPS_R9);
    check("fips_round0", seen_rk[0], FIPS_KEY);
    check("fips_idle_ready", 128'(key_ready_o), 128'(1'b1));

    // Replay from the cache: valid the very next cycle, no expansion; random back-pressure.
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    check("restart_valid", 128'(rkey_valid_o), 128'(1'b1));
    check("restart_round", 128'(rkey_round_o), 128'(4'd10));
    check("restart_round10", rkey_o, FIPS_R10);
    run_seq("restart_stall", 1'b1, cycles);

    // Key_valid together with Restart in IDLE: the new key is loaded and expanded.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    expand_model(rkey);
    restart_i = 1'b1;
    load_and_wait("key_wins", rkey, 1'b0);
    run_seq("key_wins", 1'b1, cycles);

    // All-zero key with Key_valid/Restart held high through EXPAND and ISSUE.
    expand_model(128'h0);
    load_and_wait("zero", 128'h0, 1'b1);
    check("zero_round10", rkey_o, ZERO_R10);
    check("zero_busy_in_issue", 128'(key_ready_o), 128'(1'b0));
    run_seq("zero", 1'b0, cycles);
    key_valid_i = 1'b0;
    restart_i = 1'b0;
    step();

    // Random keys with random back-pressure.
    for (int k = 0; k < 3; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand_model(rkey);
      load_and_wait("rand", rkey, 1'b0);
      run_seq("rand", 1'b1, cycles);
    end

    // Reset during EXPAND, then Restart must be ignored.
    key_valid_i = 1'b1;
    key_i = FIPS_KEY;
    step();
    key_valid_i = 1'b0;
    repeat (4) step();
    async_reset("rst_expand");
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    step();
    check("rst_expand_restart_ignored", 128'(rkey_valid_o), 128'(1'b0));

    // Reset during ISSUE at round 5.
    expand_model(FIPS_KEY);
    load_and_wait("rst_issue", FIPS_KEY, 1'b0);
    rkey_ready_i = 1'b1;
    repeat (5) step();
    rkey_ready_i = 1'b0;
    check("rst_issue_round5", 128'(rkey_round_o), 128'(4'd5));
    check("rst_issue_key5", rkey_o, model_rk[5]);
    async_reset("rst_issue");
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    step();
    check("rst_issue_restart_ignored", 128'(rkey_valid_o), 128'(1'b0));
    check("rst_issue_idle_ready", 128'(key_ready_o), 128'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
